mips_register_file: RTL
=======================

Name: mips_register_file

Overview:
- 32-entry general-purpose register file for the monocycle MIPS datapath; sits directly upstream of the ALU-source 2-to-1 mux.
- Read port B drives the mux's in0 (the register operand); read port A drives the ALU's first operand.
- Writes come from the write-back path (result mux output) at the clock edge.
- Register $zero is hardwired to 0.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_REGS, 32, number of architectural registers (power of two).
- ADDR_W, 5, register index width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- reg_write  input  1  write enable from the control unit.
- read_reg1  input  ADDR_W  rs index for read port A.
- read_reg2  input  ADDR_W  rt index for read port B.
- write_reg  input  ADDR_W  destination index (rt or rd, already muxed upstream).
- write_data  input  WIDTH  write-back value.
- read_data1  output  WIDTH  contents of read_reg1 (to ALU operand A).
- read_data2  output  WIDTH  contents of read_reg2 (to ALU-source mux in0 and data memory write data).

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-high.
- Reset: asserting reset immediately clears all NUM_REGS entries to 0 without waiting for a clock edge, so read_data1 and read_data2 read 0 while reset is high.
- Reset dominates: no write occurs on any edge where reset is high.
- Reset mid-operation: a write pending on the same edge as the reset assertion is discarded.
- Reads: purely combinational from the array, with 0 cycles of latency. A read of index 0 always returns 0.
- Write on a rising clk edge when reg_write=1, reset=0 and write_reg!=0: entry[write_reg] <= write_data. The new value is visible on the read ports after the edge.
- Write to index 0: ignored. Entry 0 is never modified and reads 0 even if a write of nonzero data was attempted.
- reg_write=0: no entry changes, regardless of write_reg and write_data.
- Same-cycle read/write of the same index without the optional feature: read returns the OLD value until the edge (read-before-write).
- Both read ports may address the same register simultaneously; both return identical data.
- No X propagation: every entry holds a defined value after the first reset.
- No wrap-around: ADDR_W exactly covers NUM_REGS, so every index is valid.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: each read port forwards write_data combinationally when reg_write=1, reset=0, write_reg!=0 and write_reg equals that port's read index (write-first). Used when the file is reused in a pipelined variant.
- Not defined: pure read-before-write behaviour as above, with no bypass logic synthesised.
- Index 0 and reset rules are unchanged in both builds.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W=5, NUM_REGS=32, WORD_W=32.
  - Named register index constants: REG_ZERO=0, REG_SP=29, REG_RA=31.
  - Typedefs reg_idx_t and word_t.
- One sub-module is natural: reg_write_decoder. It maps write_reg and reg_write to a one-hot per-entry write-enable vector, forcing bit 0 low.

Test Plan:
- Assert reset, then release; read ports at indices 5 and 31 -> read_data1=read_data2=0x00000000.
- Write 0xDEADBEEF to reg 8 (reg_write=1), next cycle read_reg1=8, read_reg2=8 -> both outputs 0xDEADBEEF.
- Write 0x12345678 to reg 0 -> reading reg 0 returns 0x00000000; no other register changes.
- reg_write=0 with write_reg=9, write_data=0xFFFFFFFF -> reg 9 keeps its prior value 0x00000011.
- Same cycle write 0xCAFEF00D to reg 3 while read_reg1=3 -> before the edge read_data1 is the old value 0x00000007 (bypass build: 0xCAFEF00D); after the edge it is 0xCAFEF00D in both builds.
- Load reg 4=0xA5A5A5A5, then assert reset between clock edges -> read_data1 (reg 4) drops to 0 before the next edge; a write pending on the reset edge is lost.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the monocycle MIPS datapath.
// The optional macro REGFILE_WRITE_BYPASS_EN is consumed by mips_register_file.
package mips_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int WORD_W     = 32;

   // Architectural register indices with special meaning
   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [WORD_W-1:0]     word_t;

endpackage

// File: rtl/mips_register_file_reg_write_decoder.sv
// One-hot write-enable decoder for the register file; entry $zero is never enabled.
module reg_write_decoder
   import mips_pkg::*;
#(
   parameter int IDX_W   = REG_ADDR_W,
   parameter int ENTRIES = NUM_REGS
) (
   input  logic               reg_write,
   input  logic [IDX_W-1:0]   write_reg,
   output logic [ENTRIES-1:0] write_en
);

   always_comb begin
      write_en = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         write_en[i] = reg_write && (write_reg == IDX_W'(i));
      end
      write_en[REG_ZERO] = 1'b0;
   end

endmodule

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two combinational read ports, one clocked write port.
// Define REGFILE_WRITE_BYPASS_EN to forward write_data to matching read ports (write-first).
module mips_register_file #(
   parameter int WIDTH    = mips_pkg::WORD_W,
   parameter int NUM_REGS = mips_pkg::NUM_REGS,
   parameter int ADDR_W   = mips_pkg::REG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [WIDTH-1:0]  write_data,
   output logic [WIDTH-1:0]  read_data1,
   output logic [WIDTH-1:0]  read_data2
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(mips_pkg::REG_ZERO);

   logic [NUM_REGS-1:0] write_en;
   logic [WIDTH-1:0]    entries [NUM_REGS];

   reg_write_decoder #(
      .IDX_W   (ADDR_W),
      .ENTRIES (NUM_REGS)
   ) u_write_decoder (
      .reg_write (reg_write),
      .write_reg (write_reg),
      .write_en  (write_en)
   );

   // Entry 0 is only ever cleared, so it reduces to a constant zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            entries[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (write_en[i]) begin
               entries[i] <= write_data;
            end
         end
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   logic bypass_live;
   assign bypass_live = reg_write && !reset && (write_reg != ZERO_IDX);
`endif

   always_comb begin
      read_data1 = entries[read_reg1];
      if (read_reg1 == ZERO_IDX) begin
         read_data1 = '0;
      end
`ifdef REGFILE_WRITE_BYPASS_EN
      else if (bypass_live && (write_reg == read_reg1)) begin
         read_data1 = write_data;
      end
`endif
   end

   always_comb begin
      read_data2 = entries[read_reg2];
      if (read_reg2 == ZERO_IDX) begin
         read_data2 = '0;
      end
`ifdef REGFILE_WRITE_BYPASS_EN
      else if (bypass_live && (write_reg == read_reg2)) begin
         read_data2 = write_data;
      end
`endif
   end

endmodule
